// File: rtl/rtc_seg_scan.sv
// rtc_seg_scan: multiplexes six frame-snapshotted 7-seg codes with blanking, 8-level PWM and a blinking colon
module rtc_seg_scan #(
  parameter int SLOT_CYC  = 1032,
  parameter int BLANK_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hr_m,
  input  logic [6:0] hr_l,
  input  logic [6:0] min_m,
  input  logic [6:0] min_l,
  input  logic [6:0] sec_m,
  input  logic [6:0] sec_l,
  input  logic       sec_tick,
  input  logic       colon_en,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);
  localparam int CW   = $clog2(SLOT_CYC);
  localparam int W    = CW + 1;
  localparam int STEP = (SLOT_CYC - BLANK_CYC) / 8;
  logic [CW-1:0]     slot_cnt;
  logic [2:0]        digit, bright_q;
  logic              colon_on, last, on;
  logic [5:0][6:0]   sh;
  logic [W-1:0]      on_end;
  // one extra bit keeps BLANK_CYC + 8*STEP (== SLOT_CYC) from overflowing
  always_comb begin
    last   = slot_cnt == CW'(SLOT_CYC - 1);
    on_end = W'(BLANK_CYC) + W'(STEP) * (W'(bright_q) + W'(1));
    on     = slot_cnt >= CW'(BLANK_CYC) && W'(slot_cnt) < on_end;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot_cnt <= '0;
      digit    <= '0;
      bright_q <= '0;
      colon_on <= 1'b0;
      sh       <= '1;
      an       <= '1;
      seg      <= '1;
      dp       <= 1'b1;
    end else begin
      slot_cnt <= last ? '0 : slot_cnt + 1'b1;
      if (last) digit <= digit == 3'd5 ? 3'd0 : digit + 3'd1;
      if (slot_cnt == '0) bright_q <= bright;
      if (sec_tick) colon_on <= ~colon_on;
      if (last && digit == 3'd5) sh <= {sec_l, sec_m, min_l, min_m, hr_l, hr_m};
      an  <= on ? ~(6'b1 << digit) : '1;
      seg <= on ? sh[digit] : '1;
      dp  <= ~(on && colon_en && colon_on && (digit == 3'd1 || digit == 3'd3));
    end
endmodule

// File: tb/tb_rtc_seg_scan.sv
// tb_rtc_seg_scan: directed checks of scan order, snapshot, PWM, dead time, colon and async reset
module tb_rtc_seg_scan;
  logic       clk = 1'b0, rst = 1'b0, sec_tick = 1'b0, colon_en = 1'b1;
  logic [6:0] hr_m, hr_l, min_m, min_l, sec_m, sec_l;
  logic [2:0] bright = 3'd7;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  int checks = 0, failures = 0, k = 0;
  logic col = 1'b0;
  logic [5:0][6:0] shown;
  logic [5:0][6:0] ca = {7'b0000100, 7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
  logic [5:0][6:0] cb = {7'b1001111, 7'b0000001, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0000001};
  logic [5:0][6:0] cz = '1;

  rtc_seg_scan #(.SLOT_CYC(24), .BLANK_CYC(8)) dut (
    .clk(clk), .rst(rst), .hr_m(hr_m), .hr_l(hr_l), .min_m(min_m), .min_l(min_l),
    .sec_m(sec_m), .sec_l(sec_l), .sec_tick(sec_tick), .colon_en(colon_en),
    .bright(bright), .seg(seg), .an(an), .dp(dp));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0][6:0] v);
    {sec_l, sec_m, min_l, min_m, hr_l, hr_m} = v;
  endtask

  // edge k (k>=1 after release) registers counter state cnt=(k-1)%24, slot (k-1)/24
  task automatic run_cycles(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      int c, d;
      logic on;
      logic [5:0] e_an;
      @(posedge clk); #1; k++;
      c = (k - 1) % 24;
      d = ((k - 1) / 24) % 6;
      on = c >= 8 && c < 8 + len;
      e_an = on ? ~(6'b1 << d) : 6'h3f;
      chk("an", {1'b0, an}, {1'b0, e_an});
      chk("seg", seg, on ? shown[d] : 7'h7f);
      chk("dp", {6'b0, dp}, {6'b0, !(on && colon_en && col && (d == 1 || d == 3))});
      chk("onehot", {6'b0, $countones(~an) <= 1}, 7'd1);
    end
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0; k = 0; col = 1'b0; shown = cz;
  endtask

  initial begin
    drive(ca);
    #1 rst = 1'b1;
    #1;
    chk("rst_an", {1'b0, an}, 7'h3f);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", {6'b0, dp}, 7'd1);
    @(posedge clk); #1;
    sec_tick = 1'b1;
    @(posedge clk); #1;
    sec_tick = 1'b0;
    release_rst();
    run_cycles(144, 16);
    shown = ca;
    run_cycles(72, 16);
    drive(cb);
    run_cycles(71, 16);
    sec_tick = 1'b1;
    run_cycles(1, 16);
    sec_tick = 1'b0; col = 1'b1;
    shown = cb;
    run_cycles(144, 16);
    sec_tick = 1'b1;
    run_cycles(1, 16);
    sec_tick = 1'b0; col = 1'b0;
    run_cycles(142, 16);
    drive(ca);
    run_cycles(1, 16);
    drive(cb);
    shown = ca;
    colon_en = 1'b0; sec_tick = 1'b1;
    run_cycles(1, 16);
    sec_tick = 1'b0; col = 1'b1;
    run_cycles(143, 16);
    shown = cb;
    colon_en = 1'b1; bright = 3'd0;
    run_cycles(24, 2);
    bright = 3'd3;
    run_cycles(10, 8);
    bright = 3'd7;
    run_cycles(14, 8);
    run_cycles(96, 16);
    run_cycles(12, 16);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", {1'b0, an}, 7'h3f);
    chk("arst_seg", seg, 7'h7f);
    chk("arst_dp", {6'b0, dp}, 7'd1);
    @(posedge clk); #1;
    sec_tick = 1'b1;
    @(posedge clk); #1;
    sec_tick = 1'b0;
    release_rst();
    run_cycles(144, 16);
    shown = cb;
    run_cycles(288, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rtc_seg_scan.md
Name: rtc_seg_scan

Overview:
- Downstream display stage for the real-time clock counter block.
- Takes the six active-low 7-segment codes (HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L) and time-multiplexes them onto one shared segment bus with six active-low digit enables.
- Adds anti-ghosting blank time, 8-level brightness PWM, frame-coherent input snapshot and a blinking colon on the decimal-point line.

Parameters:
- SLOT_CYC, 1032: clk cycles per digit slot.
- BLANK_CYC, 8: cycles at the start of each slot with all digits off. SLOT_CYC-BLANK_CYC must be a positive multiple of 8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hr_m, hr_l, min_m, min_l, sec_m, sec_l  in  7 each  active-low segment codes, bit6=a ... bit0=g.
- sec_tick  in  1  one-cycle pulse per second from the timebase.
- colon_en  in  1  1 = colon blinks, 0 = colon off.
- bright  in  3  brightness level 0..7.
- seg  out  7  shared segment bus, active-low.
- an  out  6  digit enables, active-low. an[0]=hr_m (leftmost) ... an[5]=sec_l.
- dp  out  1  decimal-point/colon segment, active-low.

Behaviour:
- Reset (async, any time, including mid-slot) forces:
  - outputs: an=6'b111111, seg=7'b1111111, dp=1.
  - state: slot_cnt=0, digit=0, colon_on=0, bright_q=0, all six shadow codes=7'b1111111.
- Reset release: counting starts on the first rising edge with rst=0.
- slot_cnt counts 0..SLOT_CYC-1 and wraps to 0. On wrap, digit advances 0→1→…→5→0.
- Frame snapshot:
  - Load all six inputs into the shadow registers in the cycle where digit==5 and slot_cnt==SLOT_CYC-1.
  - Input changes at any other time are invisible until the next frame boundary.
  - The first frame after reset displays blank.
- Brightness:
  - bright_q loads from bright when slot_cnt==0; it is held for the whole slot.
  - ACTIVE=SLOT_CYC-BLANK_CYC, STEP=ACTIVE/8, on_len=(bright_q+1)*STEP. Size the multiplier to fit SLOT_CYC without truncation.
- Slot phases, evaluated on the current state:
  - BLANK: slot_cnt<BLANK_CYC. All digits off.
  - ON: BLANK_CYC<=slot_cnt<BLANK_CYC+on_len. an[digit]=0, all other an bits 1. seg=shadow[digit].
  - OFF: remainder of the slot. All digits off.
  - "All digits off" means an=6'b111111, seg=7'b1111111, dp=1.
  - bright=7 gives an ON window equal to ACTIVE; bright=0 gives STEP cycles.
- Output latency: seg, an and dp are registered. Outputs in cycle N+1 reflect counter state in cycle N. No combinational path from inputs to outputs.
- Colon:
  - colon_on toggles on each sec_tick cycle.
  - dp=0 only during the ON phase of digit 1 or digit 3, with colon_en=1 and colon_on=1. Otherwise dp=1.
  - sec_tick is ignored while rst=1.
  - colon_en=0 does not stop the toggling; only dp is masked.
- Simultaneous events:
  - sec_tick at a frame boundary: both the snapshot and the toggle take effect.
  - bright changing at slot_cnt==0: the new value is used for that slot.
- Never more than one an bit low in any cycle. Never an an bit low during BLANK (guarantees the dead time between digits).

Test Plan:
All scenarios use SLOT_CYC=24, BLANK_CYC=8, giving STEP=2.
- Reset/idle: assert rst mid-ON, async with no clock edge → an=111111, seg=1111111, dp=1 immediately. After release, frame 0 is blank (shadow=all 1s) even with inputs driven.
- Snapshot: inputs hr_m..sec_l = codes for 1,2,3,4,5,9; bright=7.
  - Frame 2 shows an[0]=0 with seg=1001111 for 16 cycles, then an[1] with 0010010, …, an[5] with 0000100.
  - Changing inputs mid-frame 2 alters nothing until frame 3.
- Brightness: bright=0 → each an low exactly 2 consecutive cycles per 24-cycle slot, starting 9 cycles after slot_cnt=0 (8 blank + 1 register). bright=3 → 8 cycles. Changing bright mid-slot affects only the next slot.
- Dead time: over 10 frames, check 8 cycles of an=111111 before every digit. Assert one-hot-low or all-high on an every cycle.
- Colon:
  - colon_en=1, one sec_tick pulse → dp=0 only during ON of digits 1 and 3. A second pulse → dp stays 1.
  - colon_en=0 → dp=1 always.
  - sec_tick during rst → colon_on stays 0.
- Wrap: run past digit 5 → the digit after an[5] is an[0]. slot_cnt wraps at 23. Snapshot occurs on exactly that boundary cycle.
